// File: rtl/iir_inv.sv
// Inverse of the fixed 2nd-order filter (h1 = x+x1+x2, y = h1+2*h1_1+3*h1_2).
// Define IIR_INV_CHECK_EN to enable the range checks, the ERR state and err.
module iir_inv #(
    parameter int YW = 12,
    parameter int XW = 4,
    parameter int HW = 8,
    parameter int IW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [YW-1:0] y_in,
    input  logic          in_valid,
    input  logic          clear,
    output logic [XW-1:0] x_out,
    output logic          out_valid,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hd1_q, hd1_d, hd2_q, hd2_d;
    logic [XW-1:0] xd1_q, xd1_d, xd2_q, xd2_d;
    logic [XW-1:0] x_out_q, x_out_d;
    logic          out_valid_q, out_valid_d;

    logic signed [IW-1:0] y_ext, hd1_ext, hd2_ext, xd1_ext, xd2_ext;
    logic signed [IW-1:0] hr, xr;
    logic                 chk_fail;

    // Reverse both recursions in signed arithmetic so corrupt input shows up negative.
    always_comb begin
        y_ext   = {{(IW-YW){1'b0}}, y_in};
        hd1_ext = {{(IW-HW){1'b0}}, hd1_q};
        hd2_ext = {{(IW-HW){1'b0}}, hd2_q};
        xd1_ext = {{(IW-XW){1'b0}}, xd1_q};
        xd2_ext = {{(IW-XW){1'b0}}, xd2_q};
        hr      = y_ext - (hd1_ext <<< 1) - (hd2_ext <<< 1) - hd2_ext;
        xr      = hr - xd1_ext - xd2_ext;
    end

`ifdef IIR_INV_CHECK_EN
    // h1 is a sum of three x samples, so its legal ceiling is 3*xmax.
    localparam logic signed [IW-1:0] X_MAX = IW'((1 << XW) - 1);
    localparam logic signed [IW-1:0] H_MAX = IW'(3 * ((1 << XW) - 1));

    logic hr_ok, xr_ok;

    always_comb begin
        hr_ok    = !hr[IW-1] && (hr <= H_MAX);
        xr_ok    = !xr[IW-1] && (xr <= X_MAX);
        chk_fail = !(hr_ok && xr_ok);
    end
`else
    logic unused_bits;

    always_comb begin
        chk_fail    = 1'b0;
        unused_bits = ^{hr[IW-1:HW], xr[IW-1:XW]};
    end
`endif

    always_comb begin
        state_d     = state_q;
        hd1_d       = hd1_q;
        hd2_d       = hd2_q;
        xd1_d       = xd1_q;
        xd2_d       = xd2_q;
        x_out_d     = x_out_q;
        out_valid_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            hd1_d   = '0;
            hd2_d   = '0;
            xd1_d   = '0;
            xd2_d   = '0;
            x_out_d = '0;
        end else if (in_valid) begin
            hd2_d       = hd1_q;
            hd1_d       = hr[HW-1:0];
            xd2_d       = xd1_q;
            xd1_d       = xr[XW-1:0];
            out_valid_d = 1'b1;
            x_out_d     = xr[XW-1:0];
            case (state_q)
                IDLE, RUN: state_d = chk_fail ? ERR : RUN;
                ERR: begin
                    state_d = ERR;
                    x_out_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hd1_q       <= '0;
            hd2_q       <= '0;
            xd1_q       <= '0;
            xd2_q       <= '0;
            x_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hd1_q       <= hd1_d;
            hd2_q       <= hd2_d;
            xd1_q       <= xd1_d;
            xd2_q       <= xd2_d;
            x_out_q     <= x_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x_out     = x_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
`ifdef IIR_INV_CHECK_EN
    assign err       = (state_q == ERR);
`else
    assign err       = 1'b0;
`endif

endmodule
